// File: rtl/byte_serializer_if.sv
// Word-in / byte-out handshake bundle for byte_serializer.
// The byte_parity signal exists only when SERIALIZER_PARITY_EN is defined.
interface byte_serializer_if;
    logic        load;
    logic [31:0] word_in;
    logic        last_word;
    logic [1:0]  last_count;
    logic        ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        done;
`ifdef SERIALIZER_PARITY_EN
    logic        byte_parity;
`endif

    // Producer of words / consumer of bytes.
    modport master (
        output load, word_in, last_word, last_count, byte_ready,
        input  ready, byte_out, byte_valid, done
`ifdef SERIALIZER_PARITY_EN
        , input byte_parity
`endif
    );

    // The serializer itself.
    modport slave (
        input  load, word_in, last_word, last_count, byte_ready,
        output ready, byte_out, byte_valid, done
`ifdef SERIALIZER_PARITY_EN
        , output byte_parity
`endif
    );
endinterface

// File: rtl/byte_serializer.sv
// Serializes a 32-bit word MSB byte first, trimming the padding of a frame's last word.
// Optional feature macro: SERIALIZER_PARITY_EN adds byte_parity (XOR of the presented byte).
module byte_serializer (
    input  logic               clk,
    input  logic               rst_n,
    byte_serializer_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  index_reg;
    logic [31:0] word_reg;
    logic [1:0]  end_index_reg;
    logic        last_reg;
    logic        done_reg;

    logic        accept;
    logic        transfer;
    logic        at_end;
    logic [7:0]  word_bytes [4];
    logic [7:0]  byte_sel;

    assign accept   = (state_reg == IDLE) && bus.load;
    assign transfer = (state_reg == SEND) && bus.byte_ready;
    assign at_end   = (index_reg == end_index_reg);

    // Byte 0 sits in the top lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_bytes[gi] = word_reg[31 - 8*gi -: 8];
        end
    endgenerate
    assign byte_sel = word_bytes[index_reg];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.load) state_next = SEND;
            SEND:    if (bus.byte_ready && at_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Captured word, end index and byte index; loads during SEND never reach here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg      <= 32'h0;
            end_index_reg <= 2'd3;
            last_reg      <= 1'b0;
            index_reg     <= 2'd0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= transfer && at_end && last_reg;
            if (accept) begin
                word_reg      <= bus.word_in;
                last_reg      <= bus.last_word;
                end_index_reg <= bus.last_word ? bus.last_count : 2'd3;
                index_reg     <= 2'd0;
            end else if (transfer) begin
                index_reg <= at_end ? 2'd0 : index_reg + 2'd1;
            end
        end
    end

    // Output logic: byte lane is forced to zero whenever nothing is presented.
    always_comb begin
        bus.ready      = (state_reg == IDLE);
        bus.byte_valid = (state_reg == SEND);
        bus.byte_out   = (state_reg == SEND) ? byte_sel : 8'h00;
        bus.done       = done_reg;
`ifdef SERIALIZER_PARITY_EN
        bus.byte_parity = (state_reg == SEND) ? ^byte_sel : 1'b0;
`endif
    end
endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: directed frames plus randomized words
// compared against a transaction-level byte-list model.
module tb_byte_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    byte_serializer_if bus ();

    byte_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model: a frame word yields bytes [31:24] downwards, 4 of them, or last_count+1 for a last word.
    function automatic int expected_len(input bit lw, input logic [1:0] lc);
        return lw ? int'(lc) + 1 : 4;
    endfunction

    function automatic logic [7:0] expected_byte(input logic [31:0] w, input int k);
        return 8'((w >> (8 * (3 - k))) & 32'hFF);
    endfunction

    // Called at a falling edge with the block idle. stall_first forces that many
    // byte_ready=0 cycles at the start; rand_stall randomizes byte_ready afterwards.
    task automatic run_word(input logic [31:0] w, input bit lw, input logic [1:0] lc,
                            input int stall_first, input bit rand_stall, input bit inject_load);
        int n, k, cyc;
        logic br;
        n = expected_len(lw, lc);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_valid", 32'(bus.byte_valid), 32'd0);
        bus.load       = 1'b1;
        bus.word_in    = w;
        bus.last_word  = lw;
        bus.last_count = lc;
        bus.byte_ready = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        k = 0;
        cyc = 0;
        while (k < n) begin
            if (cyc > 200) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
            check("send_valid", 32'(bus.byte_valid), 32'd1);
            check("send_ready", 32'(bus.ready), 32'd0);
            check($sformatf("byte%0d", k), 32'(bus.byte_out), 32'(expected_byte(w, k)));
            check("send_done", 32'(bus.done), 32'd0);
`ifdef SERIALIZER_PARITY_EN
            check("parity", 32'(bus.byte_parity), 32'(^expected_byte(w, k)));
`endif
            if (cyc < stall_first) br = 1'b0;
            else if (rand_stall) br = 1'($urandom_range(0, 1));
            else br = 1'b1;
            bus.byte_ready = br;
            if (inject_load) begin
                bus.load    = 1'b1;
                bus.word_in = 32'hFFFF_FFFF;
            end
            if (br) k++;
            cyc++;
            @(negedge clk);
        end
        bus.load = 1'b0;
        check("end_ready", 32'(bus.ready), 32'd1);
        check("end_valid", 32'(bus.byte_valid), 32'd0);
        check("end_byte", 32'(bus.byte_out), 32'd0);
        check("end_done", 32'(bus.done), 32'(lw));
        bus.byte_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("idle_byte", 32'(bus.byte_out), 32'd0);
        $display("word %h last=%0d cnt=%0d bytes=%0d cycles=%0d", w, lw, lc, n, cyc);
    endtask

    initial begin
        bus.load       = 1'b0;
        bus.word_in    = 32'h0;
        bus.last_word  = 1'b0;
        bus.last_count = 2'd0;
        bus.byte_ready = 1'b0;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_valid", 32'(bus.byte_valid), 32'd0);
        check("rst_byte", 32'(bus.byte_out), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_word(32'hDEADBEEF, 1'b0, 2'd0, 0, 1'b0, 1'b0);
        run_word(32'h11223300, 1'b1, 2'd2, 0, 1'b0, 1'b0);
        run_word(32'hA1B2C3D4, 1'b0, 2'd0, 3, 1'b0, 1'b0);
        run_word(32'h01020304, 1'b0, 2'd0, 0, 1'b0, 1'b1);
        run_word(32'h07030000, 1'b1, 2'd1, 0, 1'b0, 1'b0);
        run_word(32'hCAFE0000, 1'b1, 2'd0, 1, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, after byte 02 has been accepted.
        bus.load = 1'b1; bus.word_in = 32'h01020304; bus.last_word = 1'b1;
        bus.last_count = 2'd3; bus.byte_ready = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        check("pre_rst_byte", 32'(bus.byte_out), 32'h02);
        @(negedge clk);
        check("pre_rst_byte", 32'(bus.byte_out), 32'h03);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", 32'(bus.ready), 32'd1);
        check("async_valid", 32'(bus.byte_valid), 32'd0);
        check("async_byte", 32'(bus.byte_out), 32'd0);
        check("async_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        $display("async reset mid-frame checked");
        run_word(32'h55AA33CC, 1'b0, 2'd0, 0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_word($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
